mux_scan_seq: RTL and testbench

Sequencer that sits directly upstream of the 8:1 byte multiplexer (`mux`) and drives its 3-bit select. On a start request it walks the enabled channels in ascending order and drives `sel` to each one. It waits a fixed settle time, captures the multiplexer output, and presents the captured byte with its channel number on a valid/ready output port. It turns the combinational mux into a scanned, flow-controlled byte stream.

---
 rtl/mux_scan_seq_pkg.sv | 16 +
 rtl/mux_scan_seq_if.sv | 28 ++
 rtl/mux_scan_seq_next_ch_find.sv | 31 +++
 rtl/mux_scan_seq.sv | 168 ++++++++++++++++
 tb/tb_mux_scan_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_seq_pkg.sv
// Shared types and constants for the mux scan sequencer.
// The optional continuous-scan build is selected with MUX_SCAN_CONT_EN.
package mux_scan_pkg;
    localparam int NCH           = 8;
    localparam int CH_W          = 3;
    localparam int CNT_W         = 4;
    localparam int DWELL_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_e;

    typedef logic [CH_W-1:0] ch_t;
endpackage

// File: rtl/mux_scan_seq_if.sv
// Control, mux-side and output-stream signals of the scan sequencer.
// master = sequencer side, slave = environment (mux + consumer + controller).
interface mux_scan_seq_if #(
    parameter int WIDTH = 8
);
    import mux_scan_pkg::*;

    logic             start;
    logic [NCH-1:0]   en_mask;
    ch_t              sel;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] out_data;
    ch_t              out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, en_mask, mux_y, out_ready,
        output sel, out_data, out_ch, out_valid, busy, done
    );

    modport slave (
        output start, en_mask, mux_y, out_ready,
        input  sel, out_data, out_ch, out_valid, busy, done
    );
endinterface

// File: rtl/mux_scan_seq_next_ch_find.sv
// Combinational channel finder: next enabled channel strictly above cur_i,
// lowest enabled channel, and a flag when nothing is enabled above cur_i.
module next_ch_find
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0] mask_i,
    input  ch_t            cur_i,
    output ch_t            next_o,
    output ch_t            lowest_o,
    output logic           last_o
);
    logic [NCH-1:0] above;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_above
            assign above[gi] = mask_i[gi] && (ch_t'(gi) > cur_i);
        end
    endgenerate

    // Scanning downward leaves the lowest matching index in each result.
    always_comb begin
        next_o   = '0;
        lowest_o = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (above[i]) next_o = ch_t'(i);
            if (mask_i[i]) lowest_o = ch_t'(i);
        end
    end

    assign last_o = ~|above;
endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer driving an 8:1 mux select and streaming captured bytes out.
// Define MUX_SCAN_CONT_EN for continuous scanning (re-latch mask and wrap).
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_seq_if.master bus
);
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [NCH-1:0]   mask_q, mask_d;
    ch_t              sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    ch_t              ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer;
    logic [NCH-1:0]   find_mask;
    ch_t              find_next, find_lowest;
    logic             find_last;

    assign xfer      = valid_q & bus.out_ready;
    // In IDLE the finder looks at the live mask to pick the first channel;
    // during a pass it walks the latched mask.
    assign find_mask = (state_q == IDLE) ? bus.en_mask : mask_q;

    next_ch_find u_find (
        .mask_i   (find_mask),
        .cur_i    (sel_q),
        .next_o   (find_next),
        .lowest_o (find_lowest),
        .last_o   (find_last)
    );

`ifdef MUX_SCAN_CONT_EN
    ch_t  wrap_next, wrap_lowest;
    logic wrap_last;
    logic unused_wrap;

    next_ch_find u_wrap (
        .mask_i   (bus.en_mask),
        .cur_i    (sel_q),
        .next_o   (wrap_next),
        .lowest_o (wrap_lowest),
        .last_o   (wrap_last)
    );

    assign unused_wrap = ^{wrap_next, wrap_last};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (bus.start && (|bus.en_mask)) state_d = SETTLE;
            SETTLE: if (cnt_q == '0) state_d = HOLD;
            HOLD: begin
                if (xfer) begin
                    if (!find_last) begin
                        state_d = SETTLE;
                    end else begin
`ifdef MUX_SCAN_CONT_EN
                        state_d = (|bus.en_mask) ? SETTLE : IDLE;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d  = mask_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (|bus.en_mask) begin
                        mask_d = bus.en_mask;
                        sel_d  = find_lowest;
                        cnt_d  = DWELL_M1;
                        busy_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    data_d  = bus.mux_y;
                    ch_d    = sel_q;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (!find_last) begin
                        sel_d = find_next;
                        cnt_d = DWELL_M1;
                    end else begin
                        done_d = 1'b1;
`ifdef MUX_SCAN_CONT_EN
                        if (|bus.en_mask) begin
                            mask_d = bus.en_mask;
                            sel_d  = wrap_lowest;
                            cnt_d  = DWELL_M1;
                        end else begin
                            busy_d = 1'b0;
                        end
`else
                        busy_d = 1'b0;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed self-checking bench for mux_scan_seq (DWELL=2, mux input n = n).
// Build with MUX_SCAN_CONT_EN defined to also exercise continuous scanning.
module tb_mux_scan_seq;
    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    mux_scan_seq_if #(.WIDTH(8)) bus ();

    mux_scan_seq #(.WIDTH(8), .DWELL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model of the 8:1 mux with channel n carrying byte n.
    assign bus.mux_y = {5'b0, bus.sel};

    always #5 clk = ~clk;

    // Transfer log filled by run_pass
    logic [2:0] xch  [16];
    logic [7:0] xdat [16];
    int         xcyc [16];
    int         n_xfer;
    int         done_cnt;
    int         done_cyc;
    logic [7:0] sel_seen;
    logic       valid_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one pass with out_ready high, then clear en_mask and log ncyc samples.
    // Sample c is taken just after edge c, edge 0 being the start edge.
    task automatic run_pass(input logic [7:0] mask, input int ncyc);
        bus.en_mask   = mask;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.en_mask = 8'h00;
        n_xfer = 0; done_cnt = 0; done_cyc = -1; sel_seen = 8'h00; valid_seen = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (bus.busy) sel_seen[bus.sel] = 1'b1;
            if (bus.out_valid) valid_seen = 1'b1;
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.out_valid && bus.out_ready && n_xfer < 16) begin
                xch[n_xfer]  = bus.out_ch;
                xdat[n_xfer] = bus.out_data;
                xcyc[n_xfer] = c + 1;
                n_xfer++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [16:0] got;
        got = {bus.sel, bus.out_data, bus.out_ch, bus.out_valid, bus.busy, bus.done};
        checks++;
        if (got !== 17'h0) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", got, 17'h0);
        end
        $display("reset: sel=%0d data=%0d ch=%0d valid=%0b busy=%0b done=%0b",
                 bus.sel, bus.out_data, bus.out_ch, bus.out_valid, bus.busy, bus.done);
    endtask

    task automatic test_full_scan();
        run_pass(8'hFF, 30);
        checks++;
        if (n_xfer !== 8) begin
            failures++;
            $display("FAIL full_count got=%0d want=8", n_xfer);
        end
        for (int i = 0; i < 8 && i < n_xfer; i++) begin
            $display("full: xfer ch=%0d data=%0d edge=%0d", xch[i], xdat[i], xcyc[i]);
            checks++;
            if (xch[i] !== 3'(i) || xdat[i] !== 8'(i) || xcyc[i] !== 3 + 3 * i) begin
                failures++;
                $display("FAIL full_xfer%0d got ch=%0d data=%0d edge=%0d want ch=%0d data=%0d edge=%0d",
                         i, xch[i], xdat[i], xcyc[i], i, i, 3 + 3 * i);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 24 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done got cnt=%0d edge=%0d busy=%0b want cnt=1 edge=24 busy=0",
                     done_cnt, done_cyc, bus.busy);
        end
    endtask

    task automatic test_sparse();
        logic [2:0] exp_ch [3];
        exp_ch[0] = 3'd2; exp_ch[1] = 3'd5; exp_ch[2] = 3'd7;
        run_pass(8'b1010_0100, 15);
        checks++;
        if (n_xfer !== 3) begin
            failures++;
            $display("FAIL sparse_count got=%0d want=3", n_xfer);
        end
        for (int i = 0; i < 3 && i < n_xfer; i++) begin
            $display("sparse: xfer ch=%0d data=%0d edge=%0d", xch[i], xdat[i], xcyc[i]);
            checks++;
            if (xch[i] !== exp_ch[i] || xdat[i] !== {5'b0, exp_ch[i]} || xcyc[i] !== 3 + 3 * i) begin
                failures++;
                $display("FAIL sparse_xfer%0d got ch=%0d data=%0d edge=%0d want ch=%0d edge=%0d",
                         i, xch[i], xdat[i], xcyc[i], exp_ch[i], 3 + 3 * i);
            end
        end
        checks++;
        if (sel_seen !== 8'b1010_0100) begin
            failures++;
            $display("FAIL sparse_sel_seen got=%b want=%b", sel_seen, 8'b1010_0100);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 9) begin
            failures++;
            $display("FAIL sparse_done got cnt=%0d edge=%0d want cnt=1 edge=9", done_cnt, done_cyc);
        end
    endtask

    task automatic test_empty_mask();
        run_pass(8'h00, 6);
        $display("empty: xfers=%0d done_cnt=%0d done_edge=%0d", n_xfer, done_cnt, done_cyc);
        checks++;
        if (valid_seen !== 1'b0 || sel_seen !== 8'h00) begin
            failures++;
            $display("FAIL empty_no_output got valid_seen=%0b busy_sel=%b want 0 00000000",
                     valid_seen, sel_seen);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 0) begin
            failures++;
            $display("FAIL empty_done got cnt=%0d edge=%0d want cnt=1 edge=0", done_cnt, done_cyc);
        end
        checks++;
        if (bus.sel !== 3'd7) begin
            failures++;
            $display("FAIL idle_sel_hold got=%0d want=7", bus.sel);
        end
    endtask

    task automatic test_backpressure();
        int c;
        int held_bad;
        int xfers;
        int dcyc;
        bus.en_mask = 8'hFF; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0; bus.en_mask = 8'h00;
        c = 0;
        while (!(bus.out_valid && bus.out_ch == 3'd3) && c < 40) begin
            tick();
            c++;
        end
        checks++;
        if (c !== 11) begin
            failures++;
            $display("FAIL bp_ch3_valid_edge got=%0d want=11", c);
        end
        bus.out_ready = 1'b0;
        held_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd3 || bus.out_ch !== 3'd3 || bus.sel !== 3'd3)
                held_bad++;
        end
        $display("bp: held 5 cycles valid=%0b data=%0d ch=%0d sel=%0d",
                 bus.out_valid, bus.out_data, bus.out_ch, bus.sel);
        checks++;
        if (held_bad !== 0) begin
            failures++;
            $display("FAIL bp_hold got bad_cycles=%0d want=0", held_bad);
        end
        bus.out_ready = 1'b1;
        c = 16; xfers = 0; dcyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) xfers++;
            if (bus.done) dcyc = c;
            tick();
            c++;
        end
        checks++;
        if (xfers !== 5 || dcyc !== 29) begin
            failures++;
            $display("FAIL bp_resume got xfers=%0d done_edge=%0d want xfers=5 done_edge=29", xfers, dcyc);
        end
    endtask

    task automatic test_reset_midpass();
        int c;
        int bad;
        logic [16:0] got;
        bus.en_mask = 8'hFF; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0; bus.en_mask = 8'h00;
        c = 0;
        while (!(bus.out_valid && bus.out_ch == 3'd4) && c < 40) begin
            tick();
            c++;
        end
        checks++;
        if (c !== 14) begin
            failures++;
            $display("FAIL rst_ch4_valid_edge got=%0d want=14", c);
        end
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        got = {bus.sel, bus.out_data, bus.out_ch, bus.out_valid, bus.busy, bus.done};
        $display("rst_mid: sel=%0d data=%0d ch=%0d valid=%0b busy=%0b",
                 bus.sel, bus.out_data, bus.out_ch, bus.out_valid, bus.busy);
        checks++;
        if (got !== 17'h0) begin
            failures++;
            $display("FAIL rst_mid_values got=%h want=%h", got, 17'h0);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet got bad_cycles=%0d want=0", bad);
        end
        run_pass(8'h30, 12);
        checks++;
        if (n_xfer !== 2 || xch[0] !== 3'd4 || xcyc[0] !== 3 || xch[1] !== 3'd5 || xcyc[1] !== 6) begin
            failures++;
            $display("FAIL rst_rescan got n=%0d ch0=%0d e0=%0d ch1=%0d e1=%0d want n=2 4@3 5@6",
                     n_xfer, xch[0], xcyc[0], xch[1], xcyc[1]);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int got_xfer;
        int got_done;
        bus.en_mask = 8'h01; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0; bus.en_mask = 8'h00;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_done got done=%0b busy=%0b want 1 0", bus.done, bus.busy);
        end
        bus.start = 1'b1; bus.en_mask = 8'h80;
        tick();
        bus.start = 1'b0; bus.en_mask = 8'h00;
        $display("b2b: restart sel=%0d busy=%0b done=%0b", bus.sel, bus.busy, bus.done);
        checks++;
        if (bus.sel !== 3'd7 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got sel=%0d busy=%0b done=%0b want 7 1 0", bus.sel, bus.busy, bus.done);
        end
        got_xfer = -1; got_done = -1;
        for (c = 0; c < 8; c++) begin
            if (bus.out_valid && got_xfer < 0) got_xfer = c + 1;
            if (bus.done) got_done = c;
            tick();
        end
        checks++;
        if (got_xfer !== 3 || got_done !== 3) begin
            failures++;
            $display("FAIL b2b_second got xfer_edge=%0d done_edge=%0d want 3 3", got_xfer, got_done);
        end
    endtask

`ifdef MUX_SCAN_CONT_EN
    task automatic test_continuous();
        int n;
        logic [2:0] ch_log [8];
        int cyc_log [8];
        int dn;
        int d_log [4];
        int busy_low_early;
        bus.en_mask = 8'h81; bus.start = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0; dn = 0; busy_low_early = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 10) bus.en_mask = 8'h00;
            if (bus.out_valid && n < 8) begin
                ch_log[n] = bus.out_ch;
                cyc_log[n] = c + 1;
                n++;
            end
            if (bus.done && dn < 4) begin
                d_log[dn] = c;
                dn++;
            end
            if (c < 12 && bus.busy !== 1'b1) busy_low_early++;
            tick();
        end
        checks++;
        if (n !== 4 || ch_log[0] !== 3'd0 || ch_log[1] !== 3'd7 || ch_log[2] !== 3'd0 || ch_log[3] !== 3'd7
            || cyc_log[0] !== 3 || cyc_log[3] !== 12) begin
            failures++;
            $display("FAIL cont_xfers got n=%0d first_edge=%0d want n=4 seq 0,7,0,7 edges 3..12", n, cyc_log[0]);
        end
        checks++;
        if (dn !== 2 || d_log[0] !== 6 || d_log[1] !== 12) begin
            failures++;
            $display("FAIL cont_done got n=%0d e0=%0d e1=%0d want 2 6 12", dn, d_log[0], d_log[1]);
        end
        checks++;
        if (busy_low_early !== 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_busy got early_low=%0d final=%0b want 0 0", busy_low_early, bus.busy);
        end
        $display("cont: xfers=%0d dones=%0d busy=%0b", n, dn, bus.busy);
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.en_mask = 8'h00;
        bus.out_ready = 1'b0;
        tick(); tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_full_scan();
        test_sparse();
        test_empty_mask();
        test_backpressure();
        test_reset_midpass();
        test_back_to_back();
`ifdef MUX_SCAN_CONT_EN
        test_continuous();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
